fb_writer: RTL
==============

# fb_writer

Write-side port of the character framebuffer. Accepts single-cycle register writes from the CPU bus bridge and turns them into framebuffer cell writes. It supports cursor positioning, character writes with auto-advancing cursor, and a hardware clear-screen fill. It runs in the pixel clock domain, so the framebuffer write port and the VGA scan-out read port share `CLK_PIXEL`.

## Interface
- `COLS`, 100, character columns per row
- `ROWS`, 75, character rows
- `CELL_W`, 2, bits per framebuffer cell (sprite index)
- `ADDR_W`, 13, framebuffer linear address width; must satisfy 2^ADDR_W ≥ COLS*ROWS

Ports:
- `CLK_PIXEL`  in  1  sole clock
- `RESET_N`  in  1  asynchronous, active-low reset
- `BUS_WE`  in  1  one-cycle write strobe, already synchronised to `CLK_PIXEL`
- `BUS_ADDR`  in  2  register select: 0 = CURSOR_X, 1 = CURSOR_Y, 2 = CHAR, 3 = CLEAR
- `BUS_DATA`  in  8  write data
- `BUSY`  out  1  high while a clear fill is in progress
- `FB_WE`  out  1  framebuffer write enable, registered
- `FB_ADDR`  out  ADDR_W  linear cell address, row*COLS + col, registered
- `FB_DATA`  out  CELL_W  cell value, registered
- `CURSOR_X`  out  7  current column, 0..COLS-1
- `CURSOR_Y`  out  7  current row, 0..ROWS-1

## Operation
- The block has two states: IDLE and CLEAR. Reset enters IDLE with all outputs at 0.
- **IDLE with `BUS_WE`=1:**
  - **Reg 0:** if `BUS_DATA` < COLS, `CURSOR_X` ← `BUS_DATA`. Otherwise the write is ignored.
  - **Reg 1:** if `BUS_DATA` < ROWS, `CURSOR_Y` ← `BUS_DATA`. Otherwise the write is ignored.
  - **Reg 2:** issue one write with `FB_ADDR` = `CURSOR_Y`*COLS + `CURSOR_X` and `FB_DATA` = `BUS_DATA[CELL_W-1:0]`. The upper data bits are discarded. Then advance the cursor:
    - x+1.
    - At x = COLS-1: x→0 and y+1.
    - At (COLS-1, ROWS-1): cursor wraps to (0,0).
  - **Reg 3:** latch fill value `BUS_DATA[CELL_W-1:0]`, load the fill counter to 0, and go to CLEAR.
- **CLEAR:**
  - Each cycle, `FB_WE`=1, `FB_ADDR` = counter, `FB_DATA` = fill value.
  - The counter increments every cycle.
  - After address COLS*ROWS-1 is written: return to IDLE and set the cursor to (0,0).
- **Writes while `BUSY`=1** (any register, including CLEAR) are dropped silently. No queuing.
- **`FB_WE`** is low in every cycle with no cell write. `FB_ADDR`/`FB_DATA` hold their last values when `FB_WE`=0.
- **Arithmetic:** the row*COLS product is computed to ADDR_W bits. Cursor comparisons are unsigned. The maximum address is COLS*ROWS-1, which is 7499 at default parameters.
- **Reset asserted mid-CLEAR:** the fill aborts immediately. `BUSY`, `FB_WE` and the cursor clear asynchronously, and no further writes are issued.

## Timing
- CHAR write:
  - Strobe in cycle N → `FB_WE`=1 in cycle N+1 only, with the pre-advance address.
  - `CURSOR_X`/`CURSOR_Y` show the advanced position from N+1.
- Cursor register write: strobe in N → new cursor visible in N+1.
- Back-to-back CHAR strobes in N and N+1 → writes in N+1 and N+2 at consecutive addresses. Sustained throughput is one cell per cycle.
- CLEAR:
  - Strobe in N → `BUSY`=1 and `FB_WE`=1 in cycles N+1 through N+COLS*ROWS.
  - `FB_ADDR` = 0 .. COLS*ROWS-1 in order.
  - In N+COLS*ROWS+1: `BUSY`=0, `FB_WE`=0, cursor = (0,0).
  - A strobe in the last `BUSY` cycle is dropped. A strobe in the first cycle after `BUSY` falls is accepted.
- Reset: all outputs are 0 while `RESET_N`=0. The first accepted strobe is in the first clock edge after release.

## Test plan
- **Set cursor and write:** reg0←5, reg1←2, reg2←0x03 → one `FB_WE` pulse with `FB_ADDR`=205, `FB_DATA`=3; cursor then reads (6,2).
- **Wrap:**
  - Cursor (99,74), reg2←0x01 → write at 7499; cursor becomes (0,0).
  - Cursor (99,10), CHAR → cursor becomes (0,11).
- **Out-of-range:** reg0←100, reg1←75 → cursor unchanged; `FB_WE` never asserts.
- **Clear:** reg3←0x02 → `BUSY` high for exactly 7500 cycles, addresses 0..7499 each written once with 2, cursor (0,0) after. A CHAR strobe injected mid-fill produces no extra write.
- **Reset mid-clear:** assert `RESET_N`=0 at fill address 3000 → `BUSY`/`FB_WE` drop at once. After release, the block is IDLE with no writes until the next strobe.
- **Streaming:** 10 consecutive CHAR strobes from (95,0) → 10 writes, one per cycle, at addresses 95..104; final cursor (5,1).

Source files
------------

// File: rtl/fb_writer.sv
// Write-side port of the character framebuffer: turns CPU register writes into cell writes,
// with an auto-advancing cursor and a hardware clear-screen fill.
module fb_writer #(
    parameter int unsigned COLS   = 100,
    parameter int unsigned ROWS   = 75,
    parameter int unsigned CELL_W = 2,
    parameter int unsigned ADDR_W = 13
) (
    input  logic              CLK_PIXEL,
    input  logic              RESET_N,
    input  logic              BUS_WE,
    input  logic [1:0]        BUS_ADDR,
    input  logic [7:0]        BUS_DATA,
    output logic              BUSY,
    output logic              FB_WE,
    output logic [ADDR_W-1:0] FB_ADDR,
    output logic [CELL_W-1:0] FB_DATA,
    output logic [6:0]        CURSOR_X,
    output logic [6:0]        CURSOR_Y
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(COLS * ROWS - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e              state_q;
    logic                busy_q;
    logic                fb_we_q;
    logic [ADDR_W-1:0]   fb_addr_q;
    logic [CELL_W-1:0]   fb_data_q;
    logic [6:0]          cursor_x_q;
    logic [6:0]          cursor_y_q;

    logic [ADDR_W-1:0]   char_addr;
    logic [CELL_W-1:0]   data_cell;
    logic                x_last;
    logic                y_last;

    always_comb begin
        char_addr = ADDR_W'(cursor_y_q) * ADDR_W'(COLS) + ADDR_W'(cursor_x_q);
        data_cell = BUS_DATA[CELL_W-1:0];
        x_last    = (cursor_x_q == 7'(COLS - 1));
        y_last    = (cursor_y_q == 7'(ROWS - 1));
    end

    always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            cursor_x_q <= '0;
            cursor_y_q <= '0;
        end else begin
            fb_we_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (BUS_WE) begin
                        unique case (BUS_ADDR)
                            2'd0: if (32'(BUS_DATA) < COLS) cursor_x_q <= BUS_DATA[6:0];
                            2'd1: if (32'(BUS_DATA) < ROWS) cursor_y_q <= BUS_DATA[6:0];
                            2'd2: begin
                                fb_we_q   <= 1'b1;
                                fb_addr_q <= char_addr;
                                fb_data_q <= data_cell;
                                if (x_last) begin
                                    cursor_x_q <= '0;
                                    cursor_y_q <= y_last ? 7'd0 : cursor_y_q + 7'd1;
                                end else begin
                                    cursor_x_q <= cursor_x_q + 7'd1;
                                end
                            end
                            2'd3: begin
                                // fb_addr_q doubles as the fill counter; fb_data_q holds the fill value
                                state_q   <= StClear;
                                busy_q    <= 1'b1;
                                fb_we_q   <= 1'b1;
                                fb_addr_q <= '0;
                                fb_data_q <= data_cell;
                            end
                            default: ;
                        endcase
                    end
                end
                StClear: begin
                    if (fb_addr_q == LastAddr) begin
                        state_q    <= StIdle;
                        busy_q     <= 1'b0;
                        cursor_x_q <= '0;
                        cursor_y_q <= '0;
                    end else begin
                        fb_we_q   <= 1'b1;
                        fb_addr_q <= fb_addr_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign BUSY     = busy_q;
    assign FB_WE    = fb_we_q;
    assign FB_ADDR  = fb_addr_q;
    assign FB_DATA  = fb_data_q;
    assign CURSOR_X = cursor_x_q;
    assign CURSOR_Y = cursor_y_q;

endmodule
